ram_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the team's single-port 8-bit RAM (write-enable, shared address, 1-cycle registered read).
- Accepts read/write requests from requesters A and B, issues one RAM access at a time, and returns read data with a valid strobe to the owning requester.
- Sits between the bus-side masters and the RAM macro.

---
 rtl/ram_ctrl_pkg.sv | 19 +
 rtl/rr_arb2.sv | 20 ++
 rtl/ram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM port arbiter.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    INIT  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; on a tie the requester that did not win last time wins.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic    req_a_i,
  input  logic    req_b_i,
  input  req_id_e last_i,
  output logic    gnt_a_o,
  output logic    gnt_b_o,
  output req_id_e winner_o
);

  // One-hot pick from the two requests and the previous winner
  always_comb begin
    gnt_a_o  = req_a_i & (~req_b_i | (last_i == REQ_B));
    gnt_b_o  = req_b_i & ~gnt_a_o;
    winner_o = gnt_b_o ? REQ_B : REQ_A;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing a single-port RAM
// with a one-cycle registered read.
// Optional macro RAM_CLEAR_EN: one INIT cycle after reset pulses ram_rst to
// zero the RAM; without it ram_rst is tied low.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_rst,
  output logic              busy
);

`ifdef RAM_CLEAR_EN
  localparam state_e RESET_STATE = INIT;
`else
  localparam state_e RESET_STATE = IDLE;
`endif

  state_e            state_q;
  req_id_e           last_q;
  req_id_e           owner_q;
  logic              ram_wr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;

  logic              arb_a;
  logic              arb_b;
  req_id_e           winner;
  logic              idle;
  logic              resp;
  logic              wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;

  rr_arb2 u_arb (
    .req_a_i  (a_req),
    .req_b_i  (b_req),
    .last_i   (last_q),
    .gnt_a_o  (arb_a),
    .gnt_b_o  (arb_b),
    .winner_o (winner)
  );

  // Access payload of the current winner
  always_comb begin
    wr_d   = (winner == REQ_B) ? b_wr   : a_wr;
    addr_d = (winner == REQ_B) ? b_addr : a_addr;
    din_d  = (winner == REQ_B) ? b_din  : a_din;
  end

  // Sequencer FSM and RAM-side access registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RESET_STATE;
      last_q     <= REQ_B;
      owner_q    <= REQ_A;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_a | arb_b) begin
            ram_wr_q   <= wr_d;
            ram_addr_q <= addr_d;
            ram_din_q  <= din_d;
            last_q     <= winner;
            owner_q    <= winner;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          ram_wr_q <= 1'b0;
          state_q  <= ram_wr_q ? IDLE : RESP;
        end
        RESP:    state_q <= IDLE;
        INIT:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grants and read returns; reset forces every output low at once
  assign idle     = (state_q == IDLE) & rst;
  assign resp     = (state_q == RESP) & rst;
  assign a_gnt    = idle & arb_a;
  assign b_gnt    = idle & arb_b;
  assign a_rvalid = resp & (owner_q == REQ_A);
  assign b_rvalid = resp & (owner_q == REQ_B);
  assign a_rdata  = a_rvalid ? ram_dout : '0;
  assign b_rdata  = b_rvalid ? ram_dout : '0;
  assign busy     = (state_q != IDLE) & rst;
  assign ram_wr   = ram_wr_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

`ifdef RAM_CLEAR_EN
  assign ram_rst = (state_q == INIT) & rst;
`else
  assign ram_rst = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req, a_wr, b_req, b_wr;
  logic [7:0] a_addr, a_din, b_addr, b_din;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_wr, ram_rst, busy;
  logic [7:0] ram_addr, ram_din, ram_dout;

  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_errors = 0;
  int         rst_cycles = 0;
  int         n_resets = 0;

`ifdef RAM_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_rst(ram_rst), .busy(busy)
  );

  // Single-port RAM: synchronous clear, write, registered read
  always @(posedge clk) begin
    if (ram_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      ram_dout <= 8'h00;
    end else begin
      if (ram_wr) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  always @(negedge clk) if (ram_rst) rst_cycles++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input bit is_b, input logic req, input logic wr,
                       input logic [7:0] addr, input logic [7:0] din);
    if (is_b) begin b_req = req; b_wr = wr; b_addr = addr; b_din = din; end
    else      begin a_req = req; a_wr = wr; a_addr = addr; a_din = din; end
  endtask

  task automatic all_zero(input string tag);
    check(tag, {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
                ram_wr, ram_addr, ram_din, ram_rst, busy}, 64'h0);
  endtask

  // Assert reset now, release two edges later; covers the clear cycle if built in
  task automatic reset_seq();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    n_resets++;
    #1;
    all_zero("reset_outputs");
    tick();
    tick();
    rst = 1'b1;
`ifdef RAM_CLEAR_EN
    mid();
    check("init_ram_rst", ram_rst, 1);
    check("init_busy", busy, 1);
    tick();
`else
    #1;
    check("idle_busy", busy, 0);
    check("idle_ram_rst", ram_rst, 0);
`endif
  endtask

  // One bounded access by a lone requester; ends back in IDLE
  task automatic access(input bit is_b, input logic wr, input logic [7:0] addr,
                        input logic [7:0] din, input logic [7:0] exp);
    bit got = 1'b0;
    drive(is_b, 1'b1, wr, addr, din);
    for (int i = 0; i < 20 && !got; i++) begin
      mid();
      if (is_b ? b_gnt : a_gnt) got = 1'b1;
      else tick();
    end
    check("gnt_wait", got, 1);
    tick();
    drive(is_b, 1'b0, 1'b0, 8'h00, 8'h00);
    if (!wr) begin
      tick();
      mid();
      check("rvalid", is_b ? b_rvalid : a_rvalid, 1);
      check("rdata", is_b ? b_rdata : a_rdata, 64'(exp));
    end
    tick();
  endtask

  initial begin
    int ng;
    int ka;
    int kb;
    bit order [6];
    int gcyc [6];

    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    reset_seq();

    // A writes 0x10=0xA5 then reads it back
    drive(1'b0, 1'b1, 1'b1, 8'h10, 8'hA5);
    mid();
    check("t1_gnt_w", {a_gnt, b_gnt}, 2'b10);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    mid();
    check("t1_issue_w", {ram_wr, ram_addr, ram_din, busy, a_gnt}, {1'b1, 8'h10, 8'hA5, 1'b1, 1'b0});
    tick();
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    mid();
    check("t1_gnt_r", {a_gnt, b_gnt}, 2'b10);
    check("t1_mem", mem[8'h10], 8'hA5);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    mid();
    check("t1_issue_r", {ram_wr, busy, a_rvalid}, 3'b010);
    tick();
    mid();
    check("t1_resp", {a_rvalid, a_rdata, b_rvalid, b_rdata, b_gnt}, {1'b1, 8'hA5, 1'b0, 8'h00, 1'b0});
    tick();
    mid();
    check("t1_after", {a_rvalid, a_rdata, busy}, 10'h0);
    tick();

    // Simultaneous reads after reset: A first, then B
    reset_seq();
    mem[8'h01] <= 8'h11;
    mem[8'h02] <= 8'h22;
    drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
    mid();
    check("t2_tie", {a_gnt, b_gnt}, 2'b10);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    mid();
    check("t2_issue", {b_gnt, ram_addr}, {1'b0, 8'h01});
    tick();
    mid();
    check("t2_a_resp", {a_rvalid, a_rdata, b_gnt, b_rvalid}, {1'b1, 8'h11, 1'b0, 1'b0});
    tick();
    mid();
    check("t2_b_gnt", {a_gnt, b_gnt}, 2'b01);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    mid();
    check("t2_b_resp", {b_rvalid, b_rdata, a_rvalid, a_rdata}, {1'b1, 8'h22, 1'b0, 8'h00});
    tick();

    // Sustained write contention: strict alternation, one grant every 2 cycles
    ng = 0; ka = 0; kb = 0;
    drive(1'b0, 1'b1, 1'b1, 8'h20, 8'h40);
    drive(1'b1, 1'b1, 1'b1, 8'h30, 8'h50);
    for (int c = 0; c < 40 && ng < 6; c++) begin
      bit ga;
      bit gb;
      mid();
      ga = a_gnt;
      gb = b_gnt;
      if (ga || gb) begin
        order[ng] = gb;
        gcyc[ng] = c;
        ng++;
      end
      tick();
      if (ga) begin ka++; drive(1'b0, 1'b1, 1'b1, 8'(8'h20 + ka), 8'(8'h40 + ka)); end
      if (gb) begin kb++; drive(1'b1, 1'b1, 1'b1, 8'(8'h30 + kb), 8'(8'h50 + kb)); end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("t3_grants", ng, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_order%0d", i), order[i], 64'(i % 2));
      check($sformatf("t3_cycle%0d", i), gcyc[i], 64'(2 * i));
    end
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b0, 8'(8'h20 + i), 8'h00, 8'(8'h40 + i));
      access(1'b1, 1'b0, 8'(8'h30 + i), 8'h00, 8'(8'h50 + i));
    end

    // Reset during ISSUE of a read: dropped, and the next tie goes to A
    drive(1'b0, 1'b1, 1'b0, 8'h21, 8'h00);
    mid();
    check("t4_gnt", a_gnt, 1);
    tick();
    reset_seq();
    for (int c = 0; c < 4; c++) begin
      mid();
      check("t4_no_rvalid", {a_rvalid, b_rvalid}, 2'b00);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h11, 8'h00);
    mid();
    check("t4_tie", {a_gnt, b_gnt}, 2'b10);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    tick();

    // Lone B holding req: granted on every IDLE visit
    mem[8'h60] <= 8'h66;
    drive(1'b1, 1'b1, 1'b0, 8'h60, 8'h00);
    for (int c = 0; c < 9; c++) begin
      mid();
      check($sformatf("t5_gnt%0d", c), b_gnt, 64'(c % 3 == 0));
      check($sformatf("t5_rv%0d", c), b_rvalid, 64'(c % 3 == 2));
      if (c % 3 == 2) check("t5_rdata", b_rdata, 8'h66);
      if (c == 8) drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      tick();
    end

    // RAM clear across reset
    access(1'b0, 1'b1, 8'h03, 8'h5A, 8'h00);
    reset_seq();
    access(1'b0, 1'b0, 8'h03, 8'h00, CLEAR ? 8'h00 : 8'h5A);

    check("ram_rst_cycles", rst_cycles, CLEAR ? 64'(n_resets) : 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
